// File: rtl/gshare_pkg.sv
// Shared types and counter helpers for the gshare branch predictor.
package gshare_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest counter supported; helpers work on this width and callers slice down.
    localparam int MAX_CTR_BITS = 4;

    typedef logic [MAX_CTR_BITS-1:0] ctr_t;

    // Weakly-not-taken: the largest value whose MSB is still 0.
    function automatic ctr_t wnt(input int ctr_bits);
        return ctr_t'((1 << (ctr_bits - 1)) - 1);
    endfunction

    function automatic ctr_t sat_next(input ctr_t ctr, input logic taken, input int ctr_bits);
        ctr_t top;
        top = ctr_t'((1 << ctr_bits) - 1);
        if (taken) begin
            return (ctr == top) ? ctr : ctr + 4'd1;
        end
        return (ctr == '0) ? ctr : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch/ID facing signals of the gshare predictor: lookup, resolved update, status.
interface gshare_predictor_if #(
    parameter int INDEX_BITS = 10,
    parameter int HIST_BITS  = 8,
    parameter int STAT_BITS  = 32
);
    logic                  FREEZE;
    logic [31:0]           LOOKUP_PC;
    logic                  PRED_TAKEN;
    logic [INDEX_BITS-1:0] PRED_IDX;
    logic                  READY;
    logic                  UPD_VALID;
    logic [INDEX_BITS-1:0] UPD_IDX;
    logic                  UPD_TAKEN;
    logic                  UPD_PRED;
    logic                  MISPREDICT;
    logic [HIST_BITS-1:0]  GHR;
    logic [STAT_BITS-1:0]  BR_COUNT;
    logic [STAT_BITS-1:0]  MISS_COUNT;

    modport master (
        output FREEZE, LOOKUP_PC, UPD_VALID, UPD_IDX, UPD_TAKEN, UPD_PRED,
        input  PRED_TAKEN, PRED_IDX, READY, MISPREDICT, GHR, BR_COUNT, MISS_COUNT
    );

    modport slave (
        input  FREEZE, LOOKUP_PC, UPD_VALID, UPD_IDX, UPD_TAKEN, UPD_PRED,
        output PRED_TAKEN, PRED_IDX, READY, MISPREDICT, GHR, BR_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/gshare_pht.sv
// Pattern history table: unreset counter array, async lookup read, clocked write that
// either loads the init value or applies a saturating step to the addressed counter.
module gshare_pht
    import gshare_pkg::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int CTR_BITS   = 2
) (
    input  logic                  CLK,
    input  logic                  wr_en,
    input  logic                  wr_init,
    input  logic                  wr_taken,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0]   rd_data
);
    localparam int DEPTH = 1 << INDEX_BITS;

    logic [CTR_BITS-1:0] mem [DEPTH];
    ctr_t                cur_ext;
    ctr_t                next_ext;
    logic [CTR_BITS-1:0] wr_data;

    assign rd_data = mem[rd_idx];

    always_comb begin
        cur_ext                = '0;
        cur_ext[CTR_BITS-1:0]  = mem[wr_idx];
        next_ext               = wr_init ? wnt(CTR_BITS) : sat_next(cur_ext, wr_taken, CTR_BITS);
        wr_data                = next_ext[CTR_BITS-1:0];
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: table init sequencing, global history, mispredict pulse
// and saturating branch/miss statistics around the PHT.
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int HIST_BITS  = 8,
    parameter int CTR_BITS   = 2,
    parameter int STAT_BITS  = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    gshare_predictor_if.slave  bus
);
    localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;
    localparam logic [STAT_BITS-1:0]  STAT_MAX = '1;

    if (HIST_BITS > INDEX_BITS) begin : g_bad_hist
        $error("gshare_predictor: HIST_BITS (%0d) must not exceed INDEX_BITS (%0d)", HIST_BITS, INDEX_BITS);
    end
    if (CTR_BITS < 1 || CTR_BITS > MAX_CTR_BITS) begin : g_bad_ctr
        $error("gshare_predictor: CTR_BITS (%0d) must be within 1..%0d", CTR_BITS, MAX_CTR_BITS);
    end

    state_t                state_reg, state_next;
    logic [INDEX_BITS-1:0] ptr_reg, ptr_next;
    logic [HIST_BITS-1:0]  ghr_reg, ghr_next;
    logic                  mispredict_reg, mispredict_next;
    logic [STAT_BITS-1:0]  br_count_reg, br_count_next;
    logic [STAT_BITS-1:0]  miss_count_reg, miss_count_next;

    logic [HIST_BITS-1:0]  ghr_shift;
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic                  pht_we;
    logic                  pht_init;
    logic [INDEX_BITS-1:0] pht_widx;
    logic [CTR_BITS-1:0]   pht_rdata;
    logic                  unused_pc_bits;

    if (HIST_BITS == 1) begin : g_ghr_one
        assign ghr_shift = bus.UPD_TAKEN;
    end else begin : g_ghr_shift
        assign ghr_shift = {ghr_reg[HIST_BITS-2:0], bus.UPD_TAKEN};
    end

    always_comb begin
        ghr_ext                 = '0;
        ghr_ext[HIST_BITS-1:0]  = ghr_reg;
        lookup_idx              = bus.LOOKUP_PC[INDEX_BITS+1:2] ^ ghr_ext;
    end

    assign unused_pc_bits = ^{bus.LOOKUP_PC[31:INDEX_BITS+2], bus.LOOKUP_PC[1:0]};

    gshare_pht #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) u_pht (
        .CLK      (CLK),
        .wr_en    (pht_we),
        .wr_init  (pht_init),
        .wr_taken (bus.UPD_TAKEN),
        .wr_idx   (pht_widx),
        .rd_idx   (lookup_idx),
        .rd_data  (pht_rdata)
    );

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        ghr_next        = ghr_reg;
        mispredict_next = 1'b0;
        br_count_next   = br_count_reg;
        miss_count_next = miss_count_reg;
        pht_we          = 1'b0;
        pht_init        = 1'b0;
        pht_widx        = bus.UPD_IDX;
        case (state_reg)
            INIT: begin
                // Init sweeps the whole table regardless of FREEZE or pending updates.
                pht_we   = 1'b1;
                pht_init = 1'b1;
                pht_widx = ptr_reg;
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == PTR_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bus.UPD_VALID && !bus.FREEZE) begin
                    pht_we   = 1'b1;
                    ghr_next = ghr_shift;
                    if (br_count_reg != STAT_MAX) begin
                        br_count_next = br_count_reg + 1'b1;
                    end
                    if (bus.UPD_TAKEN != bus.UPD_PRED) begin
                        mispredict_next = 1'b1;
                        if (miss_count_reg != STAT_MAX) begin
                            miss_count_next = miss_count_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg      <= INIT;
            ptr_reg        <= '0;
            ghr_reg        <= '0;
            mispredict_reg <= 1'b0;
            br_count_reg   <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            ghr_reg        <= ghr_next;
            mispredict_reg <= mispredict_next;
            br_count_reg   <= br_count_next;
            miss_count_reg <= miss_count_next;
        end
    end

    assign bus.PRED_IDX   = lookup_idx;
    assign bus.PRED_TAKEN = (state_reg == RUN) & pht_rdata[CTR_BITS-1];
    assign bus.READY      = (state_reg == RUN);
    assign bus.MISPREDICT = mispredict_reg;
    assign bus.GHR        = ghr_reg;
    assign bus.BR_COUNT   = br_count_reg;
    assign bus.MISS_COUNT = miss_count_reg;

endmodule
